// File: rtl/pwm_duty_controller.sv
// -----------------------------------------------------------------------------
// pwm_duty_controller
//
// Sequencer between the user buttons and the PWM datapath. It keeps a target
// duty set by the sum/rest buttons and ramps the applied duty (referencia)
// toward it. Ramp steps are taken only on PWM period boundaries, so the
// comparator never sees a mid-period change. Every change of referencia
// triggers one BCD conversion, handshaken on rdy with a timeout.
//
// Ports
//   clk         in   system clock (same clock as prescaler/contador)
//   rst         in   synchronous, active-low reset
//   ena         in   prescaler tick that advances contador
//   value       in   contador value
//   sum         in   raw increment button (asynchronous level)
//   rest        in   raw decrement button (asynchronous level)
//   rdy         in   BCD converter done
//   target      out  requested duty
//   referencia  out  applied duty (comparador and BCD input)
//   conv_ena    out  one-cycle BCD start pulse
//   busy        out  a conversion is outstanding (START/WAIT)
//   conv_err    out  sticky conversion-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module pwm_duty_controller #(
    parameter int RESOLUTION_BITS = 8,
    parameter int STEP            = 1,
    parameter int RAMP_DIV        = 4,
    parameter int CONV_TIMEOUT    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [RESOLUTION_BITS-1:0] value,
    input  logic                       sum,
    input  logic                       rest,
    input  logic                       rdy,
    output logic [RESOLUTION_BITS-1:0] target,
    output logic [RESOLUTION_BITS-1:0] referencia,
    output logic                       conv_ena,
    output logic                       busy,
    output logic                       conv_err
);

    localparam int RB = RESOLUTION_BITS;
    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int TW = $clog2(CONV_TIMEOUT + 1);

    localparam logic [RB:0]   STEP_W   = (RB + 1)'(STEP);
    localparam logic [RB:0]   MAX_W    = {1'b0, {RB{1'b1}}};
    localparam logic [PW-1:0] PER_LAST = PW'(RAMP_DIV - 1);
    // The timeout fires on the cycle in which the counter would step onto
    // CONV_TIMEOUT-1, which puts conv_err exactly CONV_TIMEOUT clocks after
    // the rising edge of conv_ena.
    localparam logic [TW-1:0] TMO_LAST = TW'(CONV_TIMEOUT - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Button synchronisers and rising-edge detectors.
    // Index 0 = sum, index 1 = rest. Bits [1:0] are the two synchroniser
    // flops, bit [2] is the history flop for edge detection.
    // -------------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;
    logic [2:0] btn_sync_q [2];

    assign btn_raw = {rest, sum};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            always_ff @(posedge clk) begin
                if (!rst) begin
                    btn_sync_q[gi] <= 3'b000;
                end else begin
                    btn_sync_q[gi] <= {btn_sync_q[gi][1:0], btn_raw[gi]};
                end
            end
            assign btn_pulse[gi] = btn_sync_q[gi][1] & ~btn_sync_q[gi][2];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    logic [RB-1:0] target_q, target_d;
    logic [RB-1:0] ref_q, ref_d;
    logic [PW-1:0] per_q, per_d;
    logic          ref_changed_q;
    logic          pending_q, pending_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rdy_prev_q;
    logic          conv_err_q, conv_err_d;
    state_t        state_q, state_d;

    logic          boundary;
    logic          ramp_step;
    logic          rdy_edge;
    logic          timeout_hit;
    logic [RB:0]   inc_w, dec_w, gap_w, delta_w;

    // Target: saturating increment/decrement; simultaneous presses cancel.
    always_comb begin
        inc_w    = {1'b0, target_q} + STEP_W;
        dec_w    = {1'b0, target_q} - STEP_W;
        target_d = target_q;
        if (btn_pulse[0] && !btn_pulse[1]) begin
            target_d = (inc_w > MAX_W) ? {RB{1'b1}} : inc_w[RB-1:0];
        end else if (btn_pulse[1] && !btn_pulse[0]) begin
            // A set MSB means the subtraction borrowed below zero.
            target_d = dec_w[RB] ? '0 : dec_w[RB-1:0];
        end
    end

    // Ramp: boundary is the last tick before contador wraps, so the new
    // referencia is registered in time for the first cycle of value==0.
    // The step uses target_q, so a same-cycle target change waits a step.
    always_comb begin
        boundary  = ena && (value == {RB{1'b1}});
        ramp_step = boundary && (per_q == PER_LAST) && (ref_q != target_q);

        per_d = per_q;
        if (boundary) begin
            per_d = (per_q == PER_LAST) ? '0 : per_q + 1'b1;
        end

        if (target_q > ref_q) begin
            gap_w = {1'b0, target_q} - {1'b0, ref_q};
        end else begin
            gap_w = {1'b0, ref_q} - {1'b0, target_q};
        end
        delta_w = (gap_w < STEP_W) ? gap_w : STEP_W;

        ref_d = ref_q;
        if (ramp_step) begin
            if (target_q > ref_q) begin
                ref_d = ref_q + delta_w[RB-1:0];
            end else begin
                ref_d = ref_q - delta_w[RB-1:0];
            end
        end
    end

    // Conversion bookkeeping. A set request wins over the START clear so a
    // change arriving during START is not lost.
    always_comb begin
        rdy_edge    = (state_q == S_WAIT) && rdy && !rdy_prev_q && (tmo_q != '0);
        timeout_hit = (state_q == S_WAIT) && !rdy_edge && (tmo_q == TMO_LAST);

        pending_d = pending_q;
        if (state_q == S_START) begin
            pending_d = 1'b0;
        end
        if (ref_changed_q) begin
            pending_d = 1'b1;
        end

        tmo_d = tmo_q;
        if (state_q == S_START) begin
            tmo_d = '0;
        end else if (state_q == S_WAIT) begin
            tmo_d = tmo_q + 1'b1;
        end

        conv_err_d = conv_err_q | timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            target_q      <= '0;
            ref_q         <= '0;
            per_q         <= '0;
            ref_changed_q <= 1'b0;
            pending_q     <= 1'b1;
            tmo_q         <= '0;
            rdy_prev_q    <= 1'b0;
            conv_err_q    <= 1'b0;
        end else begin
            target_q      <= target_d;
            ref_q         <= ref_d;
            per_q         <= per_d;
            ref_changed_q <= ramp_step;
            pending_q     <= pending_d;
            tmo_q         <= tmo_d;
            rdy_prev_q    <= rdy;
            conv_err_q    <= conv_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Conversion FSM: state register / next state / outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pending_q) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (rdy_edge || timeout_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        conv_ena = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_START: begin
                conv_ena = 1'b1;
                busy     = 1'b1;
            end
            S_WAIT:  busy = 1'b1;
            default: ;
        endcase
    end

    assign target     = target_q;
    assign referencia = ref_q;
    assign conv_err   = conv_err_q;

endmodule

// File: tb/tb_pwm_duty_controller.sv
module tb_pwm_duty_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] value = 8'd0;
    logic       sum = 1'b0;
    logic       rest = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] target;
    logic [7:0] referencia;
    logic       conv_ena;
    logic       busy;
    logic       conv_err;

    int checks = 0;
    int errors = 0;
    int cnt;

    pwm_duty_controller #(
        .RESOLUTION_BITS(8),
        .STEP(1),
        .RAMP_DIV(4),
        .CONV_TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ena(ena),
        .value(value),
        .sum(sum),
        .rest(rest),
        .rdy(rdy),
        .target(target),
        .referencia(referencia),
        .conv_ena(conv_ena),
        .busy(busy),
        .conv_err(conv_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance one clock; inputs and samples sit 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic s, input logic r);
        sum  = s;
        rest = r;
        repeat (3) tick();
        sum  = 1'b0;
        rest = 1'b0;
        repeat (3) tick();
    endtask

    // One PWM period boundary (value==255 with ena).
    task automatic period();
        value = 8'hFF;
        ena   = 1'b1;
        tick();
        value = 8'd0;
        ena   = 1'b0;
    endtask

    task automatic ramp_step();
        repeat (4) period();
    endtask

    // Called in the first WAIT cycle: skip it, then give one rdy pulse.
    task automatic ack();
        tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
    endtask

    // Called right after a referencia update: START two cycles later, then ack.
    task automatic convert(input string tag);
        tick();
        tick();
        check(tag, conv_ena, 1);
        tick();
        ack();
        check({tag, "_done"}, busy, 0);
    endtask

    initial begin
        // ---- 1: reset ----
        tick();
        tick();
        check("rst_target", target, 0);
        check("rst_ref", referencia, 0);
        check("rst_conv_ena", conv_ena, 0);
        check("rst_busy", busy, 0);
        check("rst_conv_err", conv_err, 0);
        rst = 1'b1;
        tick();
        check("init_conv_ena", conv_ena, 1);
        check("init_busy", busy, 1);
        tick();
        check("init_conv_ena_0", conv_ena, 0);
        rdy = 1'b1;               // first WAIT cycle: must be ignored
        tick();
        check("rdy_first_ign", busy, 1);
        rdy = 1'b0;
        tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("init_done", busy, 0);

        // ---- 2: ramp ----
        press(1'b1, 1'b0);
        check("press1", target, 1);
        press(1'b1, 1'b0);
        check("press2", target, 2);
        press(1'b1, 1'b0);
        check("press3", target, 3);
        repeat (3) period();
        check("ramp_hold", referencia, 0);
        period();
        check("ramp_1", referencia, 1);
        tick();
        check("ramp_lat1", conv_ena, 0);
        tick();
        check("ramp_lat2", conv_ena, 1);
        tick();
        ack();
        check("ramp_conv_done", busy, 0);
        ramp_step();
        check("ramp_2", referencia, 2);
        convert("ramp2_conv");
        ramp_step();
        check("ramp_3", referencia, 3);
        convert("ramp3_conv");
        ramp_step();
        check("ramp_settled", referencia, 3);
        repeat (3) tick();
        check("ramp_no_conv", busy, 0);

        // ---- 3: saturation ----
        for (int i = 0; i < 252; i++) press(1'b1, 1'b0);
        check("sat_255", target, 255);
        press(1'b1, 1'b0);
        check("sat_hi", target, 255);
        for (int i = 0; i < 255; i++) press(1'b0, 1'b1);
        check("sat_0", target, 0);
        press(1'b0, 1'b1);
        check("sat_lo", target, 0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        check("both_pressed", target, 1);

        // ---- 4: coalescing ----
        for (int i = 0; i < 9; i++) press(1'b1, 1'b0);
        check("coal_target", target, 10);
        check("coal_ref_hold", referencia, 3);
        ramp_step();
        check("coal_ref4", referencia, 4);
        tick();
        tick();
        check("coal_start", conv_ena, 1);
        tick();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            period();
            if (conv_ena) cnt++;
            tick();
            if (conv_ena) cnt++;
        end
        check("coal_no_start", cnt, 0);
        check("coal_ref7", referencia, 7);
        check("coal_busy", busy, 1);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("coal_idle", busy, 0);
        tick();
        check("coal_restart", conv_ena, 1);
        tick();
        ack();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (conv_ena) cnt++;
        end
        check("coal_single", cnt, 0);

        // ---- 5: timeout ----
        ramp_step();
        check("tmo_ref8", referencia, 8);
        tick();
        tick();
        check("tmo_start", conv_ena, 1);
        repeat (63) tick();
        check("tmo_not_yet", conv_err, 0);
        check("tmo_busy", busy, 1);
        tick();
        check("tmo_err", conv_err, 1);
        check("tmo_idle", busy, 0);
        ramp_step();
        check("tmo_ref9", referencia, 9);
        tick();
        tick();
        check("tmo_next_conv", conv_ena, 1);
        check("tmo_sticky", conv_err, 1);
        tick();

        // ---- 6: reset during WAIT ----
        check("mid_busy", busy, 1);
        rst = 1'b0;
        tick();
        check("mid_ref", referencia, 0);
        check("mid_target", target, 0);
        check("mid_busy0", busy, 0);
        check("mid_err", conv_err, 0);
        rst = 1'b1;
        tick();
        check("mid_init_conv", conv_ena, 1);
        tick();
        ack();
        check("mid_done", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
